// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS EX stage: ALU controls, MDU ops/reads,
// forward selects, destination selects and the MDU sequencer states.
package mips_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam logic [1:0] MDU_RD_NONE = 2'd0;
    localparam logic [1:0] MDU_RD_HI   = 2'd1;
    localparam logic [1:0] MDU_RD_LO   = 2'd2;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_RESULTW = 2'd1;
    localparam logic [1:0] FWD_ALUOUTM = 2'd2;
    localparam logic [1:0] FWD_ZERO    = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// then a final cycle where the sign-corrected result is presented with done.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, dvd;
    logic             neg_q, neg_r, div0;
    logic [WIDTH-1:0] mag_a, mag_b, rem_sub;
    logic [WIDTH:0]   rem_sh;
    logic             fits;

    always_comb begin
        mag_a   = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
        mag_b   = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;
        rem_sh  = {rem, quo[WIDTH-1]};
        fits    = rem_sh >= {1'b0, dvs};
        // partial remainder stays below the divisor, so WIDTH-bit wrap is exact
        rem_sub = rem_sh[WIDTH-1:0] - dvs;
    end

    assign done      = busy && (cnt == '0);
    assign quotient  = div0 ? '1  : (neg_q ? -quo : quo);
    assign remainder = div0 ? dvd : (neg_r ? -rem : rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            dvd   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CNT_W'(WIDTH);
            rem   <= '0;
            quo   <= mag_a;
            dvs   <= mag_b;
            dvd   <= dividend;
            neg_q <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn && dividend[WIDTH-1];
            div0  <= (divisor == '0);
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                rem <= fits ? rem_sub : rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], fits};
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_stage_mdu.sv
// MIPS EX stage: operand forwarding, ALU, destination select, plus a multi-cycle
// multiply/divide unit owning HI/LO that stalls only MDU instructions while busy.
module execute_stage_mdu
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int MUL_CYCLES    = 4,
    parameter int FWD_SEL_WIDTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_FlushE,
    input  logic [DATA_WIDTH-1:0]    i_SrcAE,
    input  logic [DATA_WIDTH-1:0]    i_SrcBE,
    input  logic [DATA_WIDTH-1:0]    i_ResultW,
    input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]    i_SignImmE,
    input  logic [3:0]               i_ALUControlE,
    input  logic [4:0]               i_ShamtE,
    input  logic [FWD_SEL_WIDTH-1:0] i_ForwardAE,
    input  logic [FWD_SEL_WIDTH-1:0] i_ForwardBE,
    input  logic                     i_ALUSrcE,
    input  logic [1:0]               i_RegDstE,
    input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
    input  logic [RF_ADDR_WIDTH-1:0] i_RdE,
    input  logic [2:0]               i_MDUOpE,
    input  logic [1:0]               i_MDUReadE,
    output logic [RF_ADDR_WIDTH-1:0] o_WriteRegE,
    output logic [DATA_WIDTH-1:0]    o_WriteDataE,
    output logic [DATA_WIDTH-1:0]    o_ALUOutE,
    output logic                     o_MDUBusyE
);

    localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [DATA_WIDTH-1:0]   src_a, src_b, alu_b, alu_res;
    logic [DATA_WIDTH-1:0]   hi, lo;
    logic [1:0]              state;
    logic [MCW-1:0]          mul_cnt;
    logic [DATA_WIDTH-1:0]   mul_a, mul_b;
    logic                    mul_sgn;
    logic [2*DATA_WIDTH-1:0] mul_ext_a, mul_ext_b, prod;
    logic                    idle, mdu_instr, start_mul, start_div, mt_ok;
    logic                    div_done;
    logic [DATA_WIDTH-1:0]   div_q, div_r;

    always_comb begin
        case (i_ForwardAE)
            FWD_RF:      src_a = i_SrcAE;
            FWD_RESULTW: src_a = i_ResultW;
            FWD_ALUOUTM: src_a = i_ALUOutM;
            default:     src_a = '0;
        endcase
        case (i_ForwardBE)
            FWD_RF:      src_b = i_SrcBE;
            FWD_RESULTW: src_b = i_ResultW;
            FWD_ALUOUTM: src_b = i_ALUOutM;
            default:     src_b = '0;
        endcase
        alu_b = i_ALUSrcE ? i_SignImmE : src_b;
    end

    always_comb begin
        alu_res = '0;
        case (i_ALUControlE)
            ALU_AND:  alu_res = src_a & alu_b;
            ALU_OR:   alu_res = src_a | alu_b;
            ALU_ADD:  alu_res = src_a + alu_b;
            ALU_XOR:  alu_res = src_a ^ alu_b;
            ALU_NOR:  alu_res = ~(src_a | alu_b);
            ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (src_a < alu_b)};
            ALU_SUB:  alu_res = src_a - alu_b;
            ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(alu_b))};
            ALU_SLL:  alu_res = alu_b << i_ShamtE;
            ALU_SRL:  alu_res = alu_b >> i_ShamtE;
            ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> i_ShamtE);
            ALU_LUI:  alu_res = alu_b << 16;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        case (i_RegDstE)
            REGDST_RT: o_WriteRegE = i_RtE;
            REGDST_RD: o_WriteRegE = i_RdE;
            REGDST_RA: o_WriteRegE = RF_ADDR_WIDTH'(31);
            default:   o_WriteRegE = i_RtE;
        endcase
        case (i_MDUReadE)
            MDU_RD_HI: o_ALUOutE = hi;
            MDU_RD_LO: o_ALUOutE = lo;
            default:   o_ALUOutE = alu_res;
        endcase
    end

    assign o_WriteDataE = src_b;

    // Only MDU instructions stall; a flushed slot is a bubble and never stalls.
    assign idle       = (state == ST_IDLE);
    assign mdu_instr  = (i_MDUOpE != MDU_NONE) || (i_MDUReadE != MDU_RD_NONE);
    assign o_MDUBusyE = !idle && mdu_instr && !i_FlushE;
    assign mt_ok      = idle && !i_FlushE;
    assign start_mul  = mt_ok && is_mul(i_MDUOpE);
    assign start_div  = mt_ok && is_div(i_MDUOpE);

    assign mul_ext_a = {{DATA_WIDTH{mul_sgn & mul_a[DATA_WIDTH-1]}}, mul_a};
    assign mul_ext_b = {{DATA_WIDTH{mul_sgn & mul_b[DATA_WIDTH-1]}}, mul_b};
    assign prod      = mul_ext_a * mul_ext_b;

    mdu_divider #(.WIDTH(DATA_WIDTH)) u_div (
        .clk       (i_clk),
        .rst       (i_rst),
        .start     (start_div),
        .sgn       (i_MDUOpE == MDU_DIV),
        .dividend  (src_a),
        .divisor   (src_b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            hi      <= '0;
            lo      <= '0;
            mul_cnt <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_sgn <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_mul) begin
                        state   <= ST_MUL;
                        mul_cnt <= MCW'(MUL_CYCLES - 1);
                        mul_a   <= src_a;
                        mul_b   <= src_b;
                        mul_sgn <= (i_MDUOpE == MDU_MULT);
                    end else if (start_div) begin
                        state <= ST_DIV;
                    end else if (mt_ok && i_MDUOpE == MDU_MTHI) begin
                        hi <= src_a;
                    end else if (mt_ok && i_MDUOpE == MDU_MTLO) begin
                        lo <= src_a;
                    end
                end
                ST_MUL: begin
                    if (mul_cnt == '0) begin
                        hi    <= prod[2*DATA_WIDTH-1:DATA_WIDTH];
                        lo    <= prod[DATA_WIDTH-1:0];
                        state <= ST_IDLE;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        hi    <= div_r;
                        lo    <= div_q;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
